// File: rtl/disk_ctrl_if.sv
// CPU bus, command port and UART byte stream of the sector-buffer disk controller.
// The controller takes the slave side; the CPU/UART/host side takes the master side.
interface disk_ctrl_if #(
    parameter int unsigned ADDR_W = 9
);
    logic [ADDR_W-1:0] addr;
    logic              cpu_we;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;

    logic              cmd_valid;
    logic              cmd_write;
    logic [29:0]       cmd_lba;
    logic              cmd_ready;
    logic              busy;
    logic              done;
    logic              error;

    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              rx_valid;
    logic [7:0]        rx_data;

    modport master (
        output addr, cpu_we, cpu_wdata, cmd_valid, cmd_write, cmd_lba,
               tx_ready, rx_valid, rx_data,
        input  cpu_rdata, cmd_ready, busy, done, error, tx_valid, tx_data
    );

    modport slave (
        input  addr, cpu_we, cpu_wdata, cmd_valid, cmd_write, cmd_lba,
               tx_ready, rx_valid, rx_data,
        output cpu_rdata, cmd_ready, busy, done, error, tx_valid, tx_data
    );
endinterface

// File: rtl/disk_ctrl.sv
// Sector-buffer disk controller: CPU word access to a byte buffer, and whole-sector
// transfers to/from a host over a byte stream with ack, timeout and bounded retry.
module disk_ctrl #(
    parameter int unsigned SECTOR_BYTES   = 512,
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_TRIES      = 3,
    parameter logic [7:0]  ACK_BYTE       = 8'hFF
) (
    input logic       clk,
    input logic       rst_n,
    disk_ctrl_if.slave bus
);
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TRY_W = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SECTOR_BYTES - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TRY_W-1:0]  TRY_LAST = TRY_W'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_ACK,
        S_DATA_RX,
        S_DATA_TX,
        S_FIN_TX,
        S_FIN_ACK
    } state_t;

    state_t            state;
    logic [7:0]        mem [SECTOR_BYTES];
    logic [31:0]       hdr;
    logic [1:0]        b_idx;
    logic [ADDR_W-1:0] idx;
    logic [TO_W-1:0]   to_cnt;
    logic [TRY_W-1:0]  tries;
    logic              tx_valid_q;
    logic [7:0]        tx_data_q;
    logic              done_q;
    logic              error_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] wa;
    logic              waiting;
    logic              retry;

    assign wa = bus.addr & ~ADDR_W'(3);

    // Buffer storage is deliberately not reset; CPU writes are only honoured in IDLE.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.cpu_we) begin
            for (int unsigned k = 0; k < 4; k++) begin
                mem[wa | ADDR_W'(k)] <= bus.cpu_wdata[8*k +: 8];
            end
        end else if (state == S_DATA_RX && bus.rx_valid) begin
            mem[idx] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= {mem[wa | ADDR_W'(3)], mem[wa | ADDR_W'(2)],
                        mem[wa | ADDR_W'(1)], mem[wa]};
        end
    end

    always_comb begin
        waiting = (state == S_ACK) || (state == S_DATA_RX) || (state == S_FIN_ACK);
        retry   = 1'b0;
        case (state)
            S_ACK, S_FIN_ACK: retry = bus.rx_valid ? (bus.rx_data != ACK_BYTE)
                                                   : (to_cnt == TO_LAST);
            S_DATA_RX:        retry = !bus.rx_valid && (to_cnt == TO_LAST);
            default:          retry = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            hdr        <= '0;
            b_idx      <= '0;
            idx        <= '0;
            to_cnt     <= '0;
            tries      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (waiting && !bus.rx_valid) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end

            // A retry restarts the whole exchange from the first header byte.
            if (retry) begin
                to_cnt <= '0;
                idx    <= '0;
                if (tries == TRY_LAST) begin
                    error_q <= 1'b1;
                    done_q  <= 1'b1;
                    state   <= S_IDLE;
                end else begin
                    tries      <= tries + TRY_W'(1);
                    b_idx      <= '0;
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= hdr[7:0];
                    state      <= S_HDR;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.cmd_valid) begin
                            hdr        <= {1'b1, bus.cmd_write, bus.cmd_lba};
                            error_q    <= 1'b0;
                            tries      <= TRY_W'(1);
                            b_idx      <= '0;
                            idx        <= '0;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= bus.cmd_lba[7:0];
                            state      <= S_HDR;
                        end
                    end
                    S_HDR: begin
                        if (bus.tx_ready) begin
                            if (b_idx == 2'd3) begin
                                tx_valid_q <= 1'b0;
                                state      <= S_ACK;
                            end else begin
                                b_idx     <= b_idx + 2'd1;
                                tx_data_q <= hdr[{b_idx + 2'd1, 3'b000} +: 8];
                            end
                        end
                    end
                    S_ACK: begin
                        if (bus.rx_valid) begin
                            idx <= '0;
                            if (hdr[30]) begin
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= mem[0];
                                state      <= S_DATA_TX;
                            end else begin
                                state <= S_DATA_RX;
                            end
                        end
                    end
                    S_DATA_RX: begin
                        if (bus.rx_valid) begin
                            if (idx == LAST_IDX) begin
                                idx        <= '0;
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= ACK_BYTE;
                                state      <= S_FIN_TX;
                            end else begin
                                idx <= idx + ADDR_W'(1);
                            end
                        end
                    end
                    S_DATA_TX: begin
                        if (bus.tx_ready) begin
                            if (idx == LAST_IDX) begin
                                idx        <= '0;
                                tx_valid_q <= 1'b0;
                                state      <= S_FIN_ACK;
                            end else begin
                                idx       <= idx + ADDR_W'(1);
                                tx_data_q <= mem[idx + ADDR_W'(1)];
                            end
                        end
                    end
                    S_FIN_TX: begin
                        if (bus.tx_ready) begin
                            tx_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                    S_FIN_ACK: begin
                        if (bus.rx_valid) begin
                            done_q <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
endmodule
